counter_4bit_monitor: RTL and testbench
=======================================

Name: counter_4bit_monitor

Overview:
- Passive checker on the loadable up-counter interface (load, load_data, count, counter reset).
- Sits beside the counter and observes every cycle.
- Each cycle it predicts the next count value and compares it with what the counter actually produces.
- Reports mismatches as pulses and keeps a saturating error count, a wrap pulse and a sync status; drives nothing back into the counter.

Parameters:
- WIDTH, 4, width of count/load_data.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high monitor reset.
- cnt_reset_n  input  1  counter's own active-low reset, observed (sampled synchronously).
- load  input  1  counter load strobe, observed.
- load_data  input  WIDTH  counter load value, observed.
- count  input  WIDTH  counter output, observed.
- clr_err  input  1  synchronous clear of err_count (and fault when enabled).
- synced  output  1  high while in TRACK (or FAULT).
- expected  output  WIDTH  predicted value of count at next rising edge.
- mismatch  output  1  one-cycle pulse: last sampled count != expected.
- wrap  output  1  one-cycle pulse: observed count went all-ones -> 0 with no load in effect.
- err_count  output  ERR_W  saturating mismatch count.
- fault  output  1  sticky fault flag (only with STICKY_FAULT_EN, else constant 0).

Behaviour:
- Interface decided: one clock (clk); reset is asynchronous, active-high (reset).
- Reset values: state=UNSYNC, synced=0, expected=0, mismatch=0, wrap=0, err_count=0, fault=0.
- Counter model (reference for prediction): at each edge, next = load ? load_data : count+1 (mod 2^WIDTH).
- Prediction at every edge where cnt_reset_n=1: expected <= load ? load_data : count+1.
- Prediction is always rebased on the observed count, so one corrupted sample gives exactly one mismatch, not a cascade.
- States:
  - UNSYNC: no compare. At an edge with cnt_reset_n=1, load prediction and go to TRACK.
  - TRACK: at every edge, mismatch <= (count != expected); err_count += mismatch, saturating at all-ones; keep predicting.
  - FAULT (macro only): entered from TRACK on the first mismatch.
- cnt_reset_n=0 sampled in any state: go to UNSYNC, expected <= 0, mismatch <= 0, wrap <= 0. err_count and fault are held.
- wrap: registered, set at the edge where the sampled count = 0 while the previous sampled count was all-ones and the previous load was 0 (TRACK only).
- A load of 0 from all-ones does not assert wrap.
- mismatch and wrap pulses are valid the cycle after the comparing edge (1-cycle latency); both default to 0 each cycle.
- clr_err=1: err_count <= 0 at that edge. This overrides a simultaneous increment, so the result is 0.
- Monitor reset mid-operation: immediate return to reset values, UNSYNC, regardless of counter activity.
- synced = (state != UNSYNC); it is a combinational decode of the state register.

Optional Feature:
- Macro: STICKY_FAULT_EN.
- Defined:
  - First TRACK mismatch sets fault=1 and moves to FAULT.
  - FAULT keeps predicting and counting errors exactly as in TRACK.
  - fault stays 1 until clr_err (which also returns the state to TRACK) or reset.
  - cnt_reset_n=0 in FAULT goes to UNSYNC but fault stays 1.
- Undefined: no FAULT state, fault tied to 0, clr_err affects err_count only.

Test Plan:
- Reset, then free-run counter from 0 for 20 cycles -> synced=1 after the first edge, mismatch never 1, err_count=0.
- Wrap: counter runs 14,15,0,1 -> wrap pulses exactly once, one cycle after the edge sampling 0; with load=1/load_data=0 at count=15 -> wrap stays 0.
- Load: load=1, load_data=9 at count=3 -> expected=9, next sampled count 9 gives no mismatch; then expected=10.
- Fault injection: force count to 7 when expected=5 -> one mismatch pulse, err_count=1, next cycle expected=8, no further errors.
- Saturation and clear: ERR_W=2, inject 5 errors -> err_count=3. Assert clr_err together with a 6th error -> err_count=0. With STICKY_FAULT_EN, fault=1 from the first error until clr_err.
- Counter reset: hold cnt_reset_n=0 for 3 cycles mid-run -> synced=0, expected=0, no mismatch. Release with count=0 -> resync with err_count unchanged.

Source files
------------

// File: rtl/counter_4bit_monitor.sv
// Passive checker for a loadable up-counter: predicts the next count each
// cycle, flags mismatches and wraps, and keeps a saturating error count.
//
// Ports:
//   clk, reset (async, active-high)   monitor clock and reset
//   cnt_reset_n, load, load_data, count  observed counter interface
//   clr_err                           synchronous clear of err_count/fault
//   synced                            high while tracking the counter
//   expected                          predicted count at the next edge
//   mismatch, wrap                    one-cycle result pulses
//   err_count                         saturating mismatch count
//   fault                             sticky fault flag
//
// Build option: define STICKY_FAULT_EN to add the FAULT state and a sticky
// fault flag; otherwise fault is tied low.

module counter_4bit_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             synced,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic             fault
);

`ifdef STICKY_FAULT_EN
    typedef enum logic [1:0] {UNSYNC, TRACK, FAULT} state_t;
`else
    typedef enum logic [1:0] {UNSYNC, TRACK} state_t;
`endif

    state_t state, state_d;

    logic [WIDTH-1:0] pred;
    logic [WIDTH-1:0] prev_count;
    logic             prev_load;
    logic             comparing;
    logic             mis_now;
    logic             wrap_now;
    logic             err_sat;

    // Prediction is always rebased on the observed count so a single bad
    // sample costs exactly one mismatch.
    assign pred      = load ? load_data : count + WIDTH'(1);
    assign comparing = (state != UNSYNC);
    assign mis_now   = comparing && (count != expected);
    assign wrap_now  = comparing && (count == '0) &&
                       (prev_count == '1) && !prev_load;
    assign err_sat   = &err_count;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNSYNC;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (!cnt_reset_n) begin
            state_d = UNSYNC;
        end else begin
            unique case (state)
                UNSYNC: state_d = TRACK;
`ifdef STICKY_FAULT_EN
                TRACK: begin
                    if (mis_now && !clr_err) begin
                        state_d = FAULT;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        state_d = TRACK;
                    end
                end
`else
                TRACK: state_d = TRACK;
`endif
                default: state_d = UNSYNC;
            endcase
        end
    end

    // Output decode
    always_comb begin
        synced = (state != UNSYNC);
    end

    // Prediction, pulses and error count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected   <= '0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
            prev_count <= '0;
            prev_load  <= 1'b0;
        end else begin
            prev_count <= count;
            prev_load  <= load;

            // Clear wins over a simultaneous increment.
            if (clr_err) begin
                err_count <= '0;
            end else if (cnt_reset_n && mis_now && !err_sat) begin
                err_count <= err_count + ERR_W'(1);
            end

            if (!cnt_reset_n) begin
                expected <= '0;
                mismatch <= 1'b0;
                wrap     <= 1'b0;
            end else begin
                expected <= pred;
                mismatch <= mis_now;
                wrap     <= wrap_now;
            end
        end
    end

`ifdef STICKY_FAULT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (clr_err) begin
            fault <= 1'b0;
        end else if (cnt_reset_n && state == TRACK && mis_now) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_counter_4bit_monitor.sv
// Scoreboard bench for counter_4bit_monitor: directed vectors push their
// expected post-edge response; a monitor pops and compares after each edge.

module tb_counter_4bit_monitor;

    typedef struct packed {
        logic       sync;
        logic [3:0] exp;
        logic       mis;
        logic       wrp;
        logic [1:0] err;
        logic       flt;
    } resp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cnt_reset_n = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_data = 4'd0;
    logic [3:0] count = 4'd0;
    logic       clr_err = 1'b0;
    logic       synced;
    logic [3:0] expected;
    logic       mismatch;
    logic       wrap;
    logic [1:0] err_count;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int vec_id = 0;

    resp_t exp_q[$];
    int    id_q[$];

    counter_4bit_monitor #(.WIDTH(4), .ERR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_reset_n (cnt_reset_n),
        .load        (load),
        .load_data   (load_data),
        .count       (count),
        .clr_err     (clr_err),
        .synced      (synced),
        .expected    (expected),
        .mismatch    (mismatch),
        .wrap        (wrap),
        .err_count   (err_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    function automatic resp_t actual();
        resp_t r;
        r.sync = synced;
        r.exp  = expected;
        r.mis  = mismatch;
        r.wrp  = wrap;
        r.err  = err_count;
        r.flt  = fault;
        return r;
    endfunction

    task automatic check(input string name, input resp_t act, input resp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got sync=%0b exp=%0d mis=%0b wrap=%0b err=%0d flt=%0b, want sync=%0b exp=%0d mis=%0b wrap=%0b err=%0d flt=%0b",
                     name, act.sync, act.exp, act.mis, act.wrp, act.err, act.flt,
                     req.sync, req.exp, req.mis, req.wrp, req.err, req.flt);
        end
    endtask

    // Monitor: one response per clock edge while the scoreboard holds entries.
    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            resp_t r;
            int    id;
            #1;
            r  = exp_q.pop_front();
            id = id_q.pop_front();
            check($sformatf("vec%0d", id), actual(), r);
        end
    end

    // Drive one cycle of stimulus (inputs change at the negedge) and push the
    // hand-computed response expected after the following rising edge.
    task automatic vec(input int rn, input int ld, input int ldd, input int cnt,
                       input int clr, input int s, input int e, input int m,
                       input int w, input int er, input int f);
        resp_t r;
        cnt_reset_n = rn[0];
        load        = ld[0];
        load_data   = 4'(ldd);
        count       = 4'(cnt);
        clr_err     = clr[0];
        r.sync = s[0];
        r.exp  = 4'(e);
        r.mis  = m[0];
        r.wrp  = w[0];
        r.err  = 2'(er);
`ifdef STICKY_FAULT_EN
        r.flt  = f[0];
`else
        r.flt  = 1'b0;
`endif
        exp_q.push_back(r);
        id_q.push_back(vec_id);
        vec_id++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_t zero;
        zero = '0;

        #7;
        check("reset_state", actual(), zero);
        @(negedge clk);
        reset = 1'b0;

        // Free run from 0; wrap expected one cycle after sampling 0 after 15.
        for (int k = 0; k < 19; k++) begin
            vec(1, 0, 0, k % 16, 0, 1, (k + 1) % 16, 0, (k == 16) ? 1 : 0, 0, 0);
        end

        // Load 9 at count 3
        vec(1, 1, 9, 3, 0,  1, 9, 0, 0, 0, 0);
        vec(1, 0, 0, 9, 0,  1, 10, 0, 0, 0, 0);
        vec(1, 0, 0, 10, 0, 1, 11, 0, 0, 0, 0);
        vec(1, 0, 0, 11, 0, 1, 12, 0, 0, 0, 0);
        vec(1, 0, 0, 12, 0, 1, 13, 0, 0, 0, 0);
        vec(1, 0, 0, 13, 0, 1, 14, 0, 0, 0, 0);
        // Natural wrap 14,15,0,1
        vec(1, 0, 0, 14, 0, 1, 15, 0, 0, 0, 0);
        vec(1, 0, 0, 15, 0, 1, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
        vec(1, 0, 0, 1, 0,  1, 2, 0, 0, 0, 0);
        // Load-to-0 from 15: no wrap
        vec(1, 1, 15, 2, 0, 1, 15, 0, 0, 0, 0);
        vec(1, 1, 0, 15, 0, 1, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        vec(1, 0, 0, 1, 0,  1, 2, 0, 0, 0, 0);
        vec(1, 0, 0, 2, 0,  1, 3, 0, 0, 0, 0);
        vec(1, 0, 0, 3, 0,  1, 4, 0, 0, 0, 0);
        vec(1, 0, 0, 4, 0,  1, 5, 0, 0, 0, 0);
        // Fault injection: 7 when 5 expected
        vec(1, 0, 0, 7, 0,  1, 8, 1, 0, 1, 1);
        vec(1, 0, 0, 8, 0,  1, 9, 0, 0, 1, 1);
        vec(1, 0, 0, 9, 0,  1, 10, 0, 0, 1, 1);
        // Saturation (ERR_W=2)
        vec(1, 0, 0, 0, 0,  1, 1, 1, 0, 2, 1);
        vec(1, 0, 0, 5, 0,  1, 6, 1, 0, 3, 1);
        vec(1, 0, 0, 0, 0,  1, 1, 1, 0, 3, 1);
        vec(1, 0, 0, 9, 0,  1, 10, 1, 0, 3, 1);
        // Clear with a simultaneous 6th error
        vec(1, 0, 0, 2, 1,  1, 3, 1, 0, 0, 0);
        vec(1, 0, 0, 3, 0,  1, 4, 0, 0, 0, 0);
        vec(1, 0, 0, 4, 0,  1, 5, 0, 0, 0, 0);
        vec(1, 0, 0, 6, 0,  1, 7, 1, 0, 1, 1);
        vec(1, 0, 0, 7, 0,  1, 8, 0, 0, 1, 1);
        // Counter reset for 3 cycles, wrong count ignored
        vec(0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 1);
        vec(0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 1);
        vec(0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 1);
        // Resync from 0, err_count kept
        vec(1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1);
        vec(1, 0, 0, 1, 0,  1, 2, 0, 0, 1, 1);

        // Asynchronous monitor reset mid-run
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset", actual(), zero);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        vec(1, 0, 0, 5, 0,  1, 6, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
